// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Types and constants shared by the UART receive front-end and the UART engine.
// Rev     : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxfe_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frontend_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_frontend_if
// Serial pin in, retimed bit stream and diagnostics out.
// Rev       : 1.0
// ============================================================================
interface uart_rx_frontend_if;
    logic       rxd;
    logic       serial_o;
    logic       bit_strb;
    logic       frame_err;
    logic [7:0] glitch_cnt;

    modport master (
        input  rxd,
        output serial_o,
        output bit_strb,
        output frame_err,
        output glitch_cnt
    );

    modport slave (
        output rxd,
        input  serial_o,
        input  bit_strb,
        input  frame_err,
        input  glitch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frontend_sync_ff.sv
`default_nettype none
// ============================================================================
// Module : sync_ff
// N-stage synchroniser for an asynchronous input; every stage resets to 1.
// Rev    : 1.0
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_frontend
// Oversampling UART receive front-end: start-bit validation, mid-bit majority
// vote and one retimed bit per bit period qualified by bit_strb.
// Rev    : 1.0
// ============================================================================
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE      = UART_OVERSAMPLE,
    parameter int CLKS_PER_SAMPLE = 27,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               nrst,
    uart_rx_frontend_if.master bus
);
    localparam int c_ph_w  = $clog2(OVERSAMPLE);
    localparam int c_div_w = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int c_half  = OVERSAMPLE / 2;

    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(OVERSAMPLE - 1);
    localparam logic [c_ph_w-1:0]  c_ph_va    = c_ph_w'(c_half - 1);
    localparam logic [c_ph_w-1:0]  c_ph_vb    = c_ph_w'(c_half);
    localparam logic [c_ph_w-1:0]  c_ph_dec   = c_ph_w'(c_half + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKS_PER_SAMPLE - 1);
    localparam logic [2:0]         c_bit_last = 3'(UART_DATA_BITS - 1);

    logic               w_rx_s;
    logic               r_rx_q;
    rxfe_state_t        r_state,  w_state_nxt;
    logic [c_ph_w-1:0]  r_ph,     w_ph_nxt;
    logic [c_div_w-1:0] r_div,    w_div_nxt;
    logic [2:0]         r_bitidx, w_bitidx_nxt;
    logic               r_s0,     w_s0_nxt;
    logic               r_s1,     w_s1_nxt;
    logic               r_serial, w_serial_nxt;
    logic               r_strb,   w_strb_nxt;
    logic               r_ferr,   w_ferr_nxt;
    logic [7:0]         r_glitch, w_glitch_nxt;

    logic w_tick;
    logic w_fall;
    logic w_decide;
    logic w_vote;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (bus.rxd),
        .o_q  (w_rx_s)
    );

    assign w_tick   = (r_div == c_div_last);
    assign w_fall   = r_rx_q & ~w_rx_s;
    assign w_decide = w_tick && (r_ph == c_ph_dec);
    // Third vote sample is the live synchronised line at the decision tick.
    assign w_vote   = maj3(r_s0, r_s1, w_rx_s);

    always_comb begin
        w_state_nxt  = r_state;
        w_ph_nxt     = r_ph;
        w_div_nxt    = r_div + c_div_w'(1);
        w_bitidx_nxt = r_bitidx;
        w_s0_nxt     = r_s0;
        w_s1_nxt     = r_s1;
        w_serial_nxt = r_serial;
        w_strb_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_glitch_nxt = r_glitch;

        if (w_tick) begin
            w_div_nxt = '0;
            w_ph_nxt  = (r_ph == c_ph_last) ? '0 : r_ph + c_ph_w'(1);
            if (r_ph == c_ph_va) w_s0_nxt = w_rx_s;
            if (r_ph == c_ph_vb) w_s1_nxt = w_rx_s;
        end

        case (r_state)
            HUNT: begin
                // Idle strobes keep the engine clocking; serial_o returns to 1 only here.
                if (w_tick && (r_ph == c_ph_last)) begin
                    w_strb_nxt   = 1'b1;
                    w_serial_nxt = 1'b1;
                end
                if (w_fall) begin
                    w_ph_nxt    = '0;
                    w_div_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_decide) begin
                    if (!w_vote) begin
                        w_serial_nxt = 1'b0;
                        w_strb_nxt   = 1'b1;
                        w_bitidx_nxt = '0;
                        w_state_nxt  = DATA;
                    end else begin
                        if (r_glitch != 8'hFF) w_glitch_nxt = r_glitch + 8'd1;
                        w_state_nxt = HUNT;
                    end
                end
            end
            DATA: begin
                if (w_decide) begin
                    w_serial_nxt = w_vote;
                    w_strb_nxt   = 1'b1;
                    w_bitidx_nxt = r_bitidx + 3'd1;
                    if (r_bitidx == c_bit_last) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_serial_nxt = w_vote;
                    w_strb_nxt   = 1'b1;
                    w_ferr_nxt   = ~w_vote;
                    w_state_nxt  = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rx_q   <= 1'b1;
            r_state  <= HUNT;
            r_ph     <= '0;
            r_div    <= '0;
            r_bitidx <= '0;
            r_s0     <= 1'b1;
            r_s1     <= 1'b1;
            r_serial <= 1'b1;
            r_strb   <= 1'b0;
            r_ferr   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_rx_q   <= w_rx_s;
            r_state  <= w_state_nxt;
            r_ph     <= w_ph_nxt;
            r_div    <= w_div_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_s0     <= w_s0_nxt;
            r_s1     <= w_s1_nxt;
            r_serial <= w_serial_nxt;
            r_strb   <= w_strb_nxt;
            r_ferr   <= w_ferr_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    assign bus.serial_o   = r_serial;
    assign bus.bit_strb   = r_strb;
    assign bus.frame_err  = r_ferr;
    assign bus.glitch_cnt = r_glitch;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_frontend
// Self-checking bench: timeline reference model plus literal frame checks.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_frontend;
    import uart_pkg::*;

    localparam int N = 20000;

    logic clk = 1'b0;
    logic nrst;

    uart_rx_frontend_if u_if ();

    uart_rx_frontend #(
        .OVERSAMPLE      (16),
        .CLKS_PER_SAMPLE (1),
        .SYNC_STAGES     (2)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if)
    );

    always #5 clk = ~clk;

    // Index t = value driven before posedge t / output observed after posedge t.
    bit rxd_w [N];
    bit rst_w [N];
    bit e_strb[N], e_ser[N], e_ferr[N];
    int e_gl  [N];
    bit o_strb[N], o_ser[N], o_ferr[N];
    int o_gl  [N];

    int total = 0;
    int bad   = 0;
    int pos   = 0;

    int         rf_fall[$];
    logic [7:0] rf_byte[$];

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (pos < N) begin
                rxd_w[pos] = v;
                rst_w[pos] = 1'b1;
            end
            pos++;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; later edges shifted by up to +-jit.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int jit);
        int         e[11];
        logic [9:0] lv;
        lv   = {stop, b, 1'b0};
        e[0] = pos;
        for (int i = 1; i <= 10; i++)
            e[i] = pos + 16 * i + ((jit > 0) ? (int'($urandom_range(0, 2 * jit)) - jit) : 0);
        for (int i = 0; i < 10; i++)
            for (int t = e[i]; t < e[i+1]; t++)
                if (t < N) begin
                    rxd_w[t] = lv[i];
                    rst_w[t] = 1'b1;
                end
        pos = e[10];
    endtask

    // Synchronised line value seen just before posedge t (two-flop synchroniser).
    function automatic bit rxs_b(input int t);
        if (t < 2) return 1'b1;
        return (rst_w[t-1] && rst_w[t-2]) ? rxd_w[t-2] : 1'b1;
    endfunction

    function automatic bit rxq_b(input int t);
        if (t < 1) return 1'b1;
        return rst_w[t-1] ? rxs_b(t-1) : 1'b1;
    endfunction

    // Timeline model: phase is time since the last reference point modulo 16;
    // a frame's bit n is decided 10+16n cycles after its falling-edge detection.
    task automatic build_model();
        int ref_t, nbit, gl, votes;
        bit inf, ser, vote;
        ref_t = 0; nbit = 0; gl = 0; inf = 1'b0; ser = 1'b1;
        for (int t = 0; t < N; t++) begin
            e_strb[t] = 1'b0;
            e_ferr[t] = 1'b0;
            if (!rst_w[t]) begin
                inf = 1'b0; ser = 1'b1; gl = 0; ref_t = t;
            end else if (!inf) begin
                if ((t - 1 - ref_t) % 16 == 15) begin
                    e_strb[t] = 1'b1;
                    ser       = 1'b1;
                end
                if (rxq_b(t) && !rxs_b(t)) begin
                    inf = 1'b1; ref_t = t; nbit = 0;
                end
            end else if (t - ref_t == 10 + 16 * nbit) begin
                votes = int'(rxs_b(t-2)) + int'(rxs_b(t-1)) + int'(rxs_b(t));
                vote  = (votes >= 2);
                if (nbit == 0 && vote) begin
                    gl  = (gl < 255) ? gl + 1 : 255;
                    inf = 1'b0;
                end else begin
                    ser       = vote;
                    e_strb[t] = 1'b1;
                    if (nbit == 9) begin
                        e_ferr[t] = !vote;
                        inf       = 1'b0;
                    end
                    nbit++;
                end
            end
            e_ser[t] = ser;
            e_gl[t]  = gl;
        end
    endtask

    task automatic grab(input int from, output int t0, output logic [9:0] v,
                        output int gap_bad, output bit fe_stop, output int nxt);
        int k, tp;
        t0 = -1; v = '0; gap_bad = 0; fe_stop = 1'b0; nxt = from; k = 0; tp = 0;
        for (int t = from; t < N && k < 10; t++) begin
            if (o_strb[t] && (k > 0 || !o_ser[t])) begin
                if (k == 0) t0 = t;
                else if (t - tp != 16) gap_bad++;
                v[k] = o_ser[t];
                tp   = t;
                k++;
                if (k == 10) begin
                    fe_stop = o_ferr[t];
                    nxt     = t + 1;
                end
            end
        end
        if (k < 10) t0 = -1;
    endtask

    task automatic chk_frame(input string nm, input int from, input logic [7:0] b,
                             input bit stop, output int t0, output int nxt);
        logic [9:0] v;
        int         gb;
        bit         fe;
        grab(from, t0, v, gb, fe, nxt);
        chk({nm, "_found"}, int'(t0 >= 0), 1);
        chk({nm, "_bits"},  int'(v), int'({stop, b, 1'b0}));
        chk({nm, "_gaps"},  gb, 0);
        chk({nm, "_ferr"},  int'(fe), int'(!stop));
    endtask

    initial begin
        int a5_f, gl_f, fe_f, brk_end, jit_f, rm_f, rm_rst, post_f;
        int t0, nxt, t1, t2, cnt0, cnt1, ts;
        logic [7:0] rb;

        for (int i = 0; i < N; i++) begin
            rxd_w[i] = 1'b1;
            rst_w[i] = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            rst_w[i] = 1'b0;
            rxd_w[i] = bit'($urandom_range(0, 1));
        end
        pos = 6;
        put(1'b1, 40);
        a5_f = pos;   send_frame(8'hA5, 1'b1, 0); put(1'b1, 30);
        gl_f = pos;   put(1'b0, 4); put(1'b1, 40);
        fe_f = pos;   send_frame(8'h00, 1'b0, 0); put(1'b0, 40);
        brk_end = pos; put(1'b1, 30);
        jit_f = pos;  send_frame(8'h3C, 1'b1, 3); send_frame(8'hC3, 1'b1, 3); put(1'b1, 30);
        rm_f = pos;   send_frame(8'h96, 1'b1, 0);
        rm_rst = rm_f + 16 * 5 + 6;
        pos = rm_rst; put(1'b1, 90);
        for (int i = 0; i < 3; i++) rst_w[rm_rst + i] = 1'b0;
        post_f = pos; send_frame(8'h5A, 1'b1, 0); put(1'b1, 30);
        for (int k = 0; k < 30; k++) begin
            put(1'b1, int'($urandom_range(0, 40)));
            rb = 8'($urandom_range(0, 255));
            rf_fall.push_back(pos);
            rf_byte.push_back(rb);
            send_frame(rb, 1'b1, int'($urandom_range(0, 3)));
        end
        put(1'b1, 30);
        for (int k = 0; k < 260; k++) begin
            put(1'b0, int'($urandom_range(1, 6)));
            put(1'b1, int'($urandom_range(20, 40)));
        end
        put(1'b1, 40);
        if (pos >= N) begin
            $display("FAIL stimulus_length actual=%0d required<%0d", pos, N);
            $fatal(1);
        end

        build_model();

        // Literal pins of the model itself.
        chk("model_a5_start_strobe", int'(e_strb[a5_f + 12]), 1);
        chk("model_a5_start_value",  int'(e_ser[a5_f + 12]), 0);
        chk("model_sat_glitch",      e_gl[N-1], 255);

        nrst     = 1'b0;
        u_if.rxd = 1'b1;
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            u_if.rxd = rxd_w[t];
            nrst     = rst_w[t];
            @(posedge clk);
            #1;
            o_strb[t] = u_if.bit_strb;
            o_ser[t]  = u_if.serial_o;
            o_ferr[t] = u_if.frame_err;
            o_gl[t]   = int'(u_if.glitch_cnt);
            chk($sformatf("strb@%0d", t),   int'(o_strb[t]), int'(e_strb[t]));
            chk($sformatf("serial@%0d", t), int'(o_ser[t]),  int'(e_ser[t]));
            chk($sformatf("ferr@%0d", t),   int'(o_ferr[t]), int'(e_ferr[t]));
            chk($sformatf("glitch@%0d", t), o_gl[t], e_gl[t]);
            if (o_strb[t] && t > 0) chk($sformatf("strb_double@%0d", t), int'(o_strb[t-1]), 0);
        end

        // Reset state and idle strobe cadence.
        for (int t = 0; t < 6; t++) begin
            chk("rst_strb",   int'(o_strb[t]), 0);
            chk("rst_serial", int'(o_ser[t]),  1);
            chk("rst_ferr",   int'(o_ferr[t]), 0);
            chk("rst_glitch", o_gl[t], 0);
        end
        t1 = -1; t2 = -1;
        for (int t = 6; t < a5_f && t2 < 0; t++)
            if (o_strb[t]) begin
                if (t1 < 0) t1 = t; else t2 = t;
            end
        chk("idle_first_strobe", t1, 21);
        chk("idle_period", t2 - t1, 16);

        // Clean byte.
        chk_frame("a5", a5_f, 8'hA5, 1'b1, t0, nxt);
        chk("a5_latency", t0 - a5_f, 12);

        // Glitch rejection.
        chk("glitch_cnt_1", o_gl[gl_f + 30], 1);
        cnt0 = 0;
        for (int t = gl_f; t < fe_f; t++) if (o_strb[t] && !o_ser[t]) cnt0++;
        chk("glitch_no_zero_strobe", cnt0, 0);

        // Framing error and break.
        chk_frame("ferr", fe_f, 8'h00, 1'b0, t0, nxt);
        ts = (t0 < 0) ? 0 : t0;
        chk("break_hold_serial", int'(o_ser[ts + 147]), 0);
        cnt0 = 0; cnt1 = 0;
        for (int t = ts + 145; t < brk_end + 4; t++)
            if (o_strb[t]) begin
                if (o_ser[t]) cnt1++; else cnt0++;
            end
        chk("break_zero_strobes", cnt0, 0);
        chk("break_idle_strobes", int'(cnt1 > 0), 1);

        // Jitter tolerance.
        chk_frame("jit0", jit_f, 8'h3C, 1'b1, t0, nxt);
        chk_frame("jit1", nxt,   8'hC3, 1'b1, t0, nxt);

        // Reset mid-frame.
        chk("midrst_serial", int'(o_ser[rm_rst]),  1);
        chk("midrst_strb",   int'(o_strb[rm_rst]), 0);
        chk_frame("post_rst", post_f, 8'h5A, 1'b1, t0, nxt);

        foreach (rf_fall[i])
            chk_frame($sformatf("rand%0d", i), rf_fall[i], rf_byte[i], 1'b1, t0, nxt);

        chk("glitch_saturated", o_gl[N-1], 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
